l1_cache_controller: RTL

Direct-mapped, write-back, write-allocate L1 cache for the LC-3b memory path. It owns the per-line valid, dirty and tag state and the line data array, and splits the CPU address into tag, index and word offset. It answers CPU word requests on a hit and sequences line writeback and line fill over the 128-bit physical-memory port on a miss. It sits between the CPU memory interface and physical memory (or the L2).

---
 rtl/l1_cache_controller_if.sv | 47 ++++
 rtl/l1_cache_controller.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/l1_cache_controller_if.sv
// ============================================================================
// Module      : l1_cache_controller_if
// Description : CPU-side word bus and physical-memory line bus seen by the
//               L1 cache controller. The slave view belongs to the cache, and
//               the master view belongs to the surrounding CPU/memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface l1_cache_controller_if;

  // CPU word interface
  logic [15:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata;
  logic         mem_resp;

  // Physical-memory line interface
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  // Cache side: it takes CPU requests and drives physical-memory requests.
  modport slave (
    input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    output mem_rdata, mem_resp,
    output pmem_address, pmem_read, pmem_write, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  // Environment side: the CPU issues requests, and memory answers line requests.
  modport master (
    output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    input  mem_rdata, mem_resp,
    input  pmem_address, pmem_read, pmem_write, pmem_wdata,
    output pmem_rdata, pmem_resp
  );

endinterface

`default_nettype wire

// File: rtl/l1_cache_controller.sv
// ============================================================================
// Module      : l1_cache_controller
// Description : Direct-mapped, write-back, write-allocate L1 cache. Hits
//               respond in the same cycle. Misses write back a dirty victim,
//               then fill the line over the 128-bit physical-memory port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module l1_cache_controller #(
  parameter int TAG_SIZE    = 9,
  parameter int INDEX_SIZE  = 3,
  parameter int OFFSET_SIZE = 3
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  l1_cache_controller_if.slave  bus
);

  localparam int LINES  = 1 << INDEX_SIZE;
  localparam int LINE_W = 16 << OFFSET_SIZE;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Per-line state: valid and dirty bits are cleared by reset, tags and data are not.
  logic [LINES-1:0]    valid_q;
  logic [LINES-1:0]    dirty_q;
  logic [TAG_SIZE-1:0] tag_q  [LINES];
  logic [LINE_W-1:0]   data_q [LINES];

  // The address of the miss in progress. It is captured so that writeback and
  // fill target a consistent line even if the CPU changes its inputs mid-miss.
  logic [TAG_SIZE-1:0]   miss_tag_q;
  logic [INDEX_SIZE-1:0] miss_index_q;

  // Address decode
  logic [TAG_SIZE-1:0]    w_tag;
  logic [INDEX_SIZE-1:0]  w_index;
  logic [OFFSET_SIZE-1:0] w_offset;
  logic [OFFSET_SIZE+3:0] w_lo_base;
  logic [OFFSET_SIZE+3:0] w_hi_base;
  logic                   w_unused;

  assign w_tag     = bus.mem_address[15 -: TAG_SIZE];
  assign w_index   = bus.mem_address[OFFSET_SIZE+1 +: INDEX_SIZE];
  assign w_offset  = bus.mem_address[1 +: OFFSET_SIZE];
  assign w_lo_base = {w_offset, 4'b0000};
  assign w_hi_base = {w_offset, 4'b1000};
  assign w_unused  = bus.mem_address[0];

  logic w_req;
  logic w_hit;
  assign w_req = bus.mem_read | bus.mem_write;
  assign w_hit = valid_q[w_index] && (tag_q[w_index] == w_tag);

  // Read data comes straight from the indexed line, whatever the state.
  assign bus.mem_rdata  = data_q[w_index][w_lo_base +: 16];
  assign bus.pmem_wdata = data_q[miss_index_q];

  logic w_resp;
  logic w_pread;
  logic w_pwrite;
  logic [15:0] w_paddr;
  logic w_do_write;
  logic w_do_fill;
  logic w_latch_miss;

  // Next-state and output decode. Reset forces every strobe low at once.
  always_comb begin
    state_d      = state_q;
    w_resp       = 1'b0;
    w_pread      = 1'b0;
    w_pwrite     = 1'b0;
    w_paddr      = {w_tag, w_index, {(OFFSET_SIZE+1){1'b0}}};
    w_do_write   = 1'b0;
    w_do_fill    = 1'b0;
    w_latch_miss = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            w_resp     = 1'b1;
            w_do_write = bus.mem_write;
          end else begin
            w_latch_miss = 1'b1;
            state_d = (valid_q[w_index] && dirty_q[w_index]) ? S_WRITEBACK : S_ALLOCATE;
          end
        end
      end
      S_WRITEBACK: begin
        w_pwrite = 1'b1;
        w_paddr  = {tag_q[miss_index_q], miss_index_q, {(OFFSET_SIZE+1){1'b0}}};
        if (bus.pmem_resp) state_d = S_ALLOCATE;
      end
      S_ALLOCATE: begin
        w_pread = 1'b1;
        w_paddr = {miss_tag_q, miss_index_q, {(OFFSET_SIZE+1){1'b0}}};
        if (bus.pmem_resp) begin
          w_do_fill = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (!rst_n) begin
      state_d      = S_IDLE;
      w_resp       = 1'b0;
      w_pread      = 1'b0;
      w_pwrite     = 1'b0;
      w_do_write   = 1'b0;
      w_do_fill    = 1'b0;
      w_latch_miss = 1'b0;
    end
  end

  assign bus.mem_resp     = w_resp;
  assign bus.pmem_read    = w_pread;
  assign bus.pmem_write   = w_pwrite;
  assign bus.pmem_address = w_paddr;

  // State register and per-line valid/dirty bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (w_do_fill) begin
        valid_q[miss_index_q] <= 1'b1;
        dirty_q[miss_index_q] <= 1'b0;
      end
      if (w_do_write) dirty_q[w_index] <= 1'b1;
    end
  end

  // Tag and data arrays plus the miss address capture. None of these is reset.
  always_ff @(posedge clk) begin
    if (w_latch_miss) begin
      miss_tag_q   <= w_tag;
      miss_index_q <= w_index;
    end
    if (w_do_fill) begin
      tag_q[miss_index_q]  <= miss_tag_q;
      data_q[miss_index_q] <= bus.pmem_rdata;
    end
    if (w_do_write) begin
      if (bus.mem_byte_enable[0]) data_q[w_index][w_lo_base +: 8] <= bus.mem_wdata[7:0];
      if (bus.mem_byte_enable[1]) data_q[w_index][w_hi_base +: 8] <= bus.mem_wdata[15:8];
    end
  end

endmodule

`default_nettype wire
